render_scheduler: RTL
=====================

RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 Parameter COOR_WIDTH, default 12: width of each framebuffer coordinate.
REQ-002 Parameter PIX_WIDTH, default 12: RGB444 pixel width.
REQ-003 Parameter NUM_LAYERS, default 4: number of painter layers; layer 0 is the background and is painted first.
REQ-004 Parameter TIMEOUT, default 400000: maximum WAIT cycles allowed per layer.
REQ-005 Parameter BLING_PERIOD, default 16: number of completed frames per show_bling toggle.
REQ-006 clk  in  1  system clock; all logic is synchronous to its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 frame_tick  in  1  one-cycle request to render a new frame (display vsync).
REQ-009 layer_en  in  NUM_LAYERS  per-layer enable mask, sampled once at frame start.
REQ-010 bling_en  in  1  enables show_bling toggling.
REQ-011 layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse to a painter.
REQ-012 layer_done  in  NUM_LAYERS  painter finished pulse (level also accepted).
REQ-013 layer_valid  in  NUM_LAYERS  painter pixel-valid strobe.
REQ-014 layer_x, layer_y  in  NUM_LAYERS*COOR_WIDTH each  flattened painter coordinates; layer i occupies bits [i*COOR_WIDTH +: COOR_WIDTH].
REQ-015 layer_pixel  in  NUM_LAYERS*PIX_WIDTH  flattened painter pixel data.
REQ-016 fb_we  out  1  framebuffer write enable.
REQ-017 fb_x, fb_y  out  COOR_WIDTH each  framebuffer write address.
REQ-018 fb_pixel  out  PIX_WIDTH  framebuffer write data.
REQ-019 fb_swap  out  1  one-cycle pulse requesting a front/back buffer swap.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 show_bling  out  1  highlight enable forwarded to the background painter.
REQ-022 overrun_cnt  out  8  count of dropped frame_tick events; saturates at 255.
REQ-023 timeout_flag  out  1  sticky; set when any layer times out.

Function
REQ-024 The FSM SHALL have states IDLE, START, WAIT, NEXT and SWAP.
REQ-025 IDLE + frame_tick: latch layer_en into en_q, set idx=0, go to START.
REQ-026 START: if en_q[idx]=1, assert layer_start[idx] for exactly 1 cycle and go to WAIT; otherwise go directly to NEXT with no pulse.
REQ-027 WAIT: the write port SHALL be granted only to layer idx; fb_we/fb_x/fb_y/fb_pixel are registered copies of layer idx inputs (1-cycle latency); valid strobes from other layers are ignored.
REQ-028 WAIT exit: layer_done[idx]=1 or timer reaching TIMEOUT-1 -> NEXT; a timeout also sets timeout_flag.
REQ-029 The WAIT timer SHALL clear on entry to START.
REQ-030 A layer_done[idx] asserted in the same cycle as layer_valid[idx] SHALL still produce that final write.
REQ-031 NEXT: if idx==NUM_LAYERS-1 go to SWAP; else increment idx and go to START.
REQ-032 SWAP: pulse fb_swap for 1 cycle, increment frame_cnt, then return to IDLE.
REQ-033 frame_cnt SHALL wrap at BLING_PERIOD-1 -> 0; on wrap, show_bling toggles if bling_en=1, else show_bling is forced to 0.
REQ-034 frame_tick outside IDLE SHALL be dropped, not queued, and SHALL increment overrun_cnt (saturating).
REQ-035 frame_tick in the SWAP cycle counts as an overrun.
REQ-036 With layer_en all zero, a frame SHALL still sequence through all layers and pulse fb_swap.
REQ-037 fb_we SHALL be 0 in IDLE, START, NEXT and SWAP, apart from the registered final write of REQ-030.

Reset
REQ-038 rst_n=0 at a clock edge SHALL force: state IDLE, idx 0, timer 0, frame_cnt 0, layer_start 0, fb_we 0, fb_x/fb_y/fb_pixel 0, fb_swap 0, busy 0, show_bling 0, overrun_cnt 0, timeout_flag 0.
REQ-039 Reset mid-frame SHALL abort the frame with no fb_swap; the first frame_tick after release starts from layer 0.

Verification
REQ-040 Scenario: layer_en=4'hF, each painter issues 3 valid writes then done, then frame_tick -> start pulses on layers 0,1,2,3 in order; 12 fb writes, each 1 cycle after its strobe; one fb_swap.
REQ-041 Scenario: layer 2 never asserts done, TIMEOUT=100 -> WAIT for layer 2 lasts 100 cycles; timeout_flag=1; layer 3 still starts; fb_swap still pulses.
REQ-042 Scenario: frame_tick pulsed 3 times while busy -> overrun_cnt=3; no extra frames rendered.
REQ-043 Scenario: bling_en=1, BLING_PERIOD=2, 4 frames -> show_bling toggles after frames 2 and 4 (0->1->0).
REQ-044 Scenario: layer 1 strobes valid during layer 0 WAIT -> no fb write from layer 1; layer_en=4'b0101 -> no start pulse for layers 1 or 3.
REQ-045 Scenario: rst_n=0 during layer 1 WAIT -> all outputs reach reset values next cycle; no fb_swap; the next frame_tick starts at layer 0.

Source files
------------

// File: rtl/render_scheduler.sv
// Frame-level sequencer for a stack of painter layers: starts each enabled painter in
// order, muxes the active painter onto the framebuffer write port, then requests a swap.
module render_scheduler #(
  parameter int COOR_WIDTH   = 12,
  parameter int PIX_WIDTH    = 12,
  parameter int NUM_LAYERS   = 4,
  parameter int TIMEOUT      = 400000,
  parameter int BLING_PERIOD = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             frame_tick,
  input  logic [NUM_LAYERS-1:0]            layer_en,
  input  logic                             bling_en,
  output logic [NUM_LAYERS-1:0]            layer_start,
  input  logic [NUM_LAYERS-1:0]            layer_done,
  input  logic [NUM_LAYERS-1:0]            layer_valid,
  input  logic [NUM_LAYERS*COOR_WIDTH-1:0] layer_x,
  input  logic [NUM_LAYERS*COOR_WIDTH-1:0] layer_y,
  input  logic [NUM_LAYERS*PIX_WIDTH-1:0]  layer_pixel,
  output logic                             fb_we,
  output logic [COOR_WIDTH-1:0]            fb_x,
  output logic [COOR_WIDTH-1:0]            fb_y,
  output logic [PIX_WIDTH-1:0]             fb_pixel,
  output logic                             fb_swap,
  output logic                             busy,
  output logic                             show_bling,
  output logic [7:0]                       overrun_cnt,
  output logic                             timeout_flag,
  output logic [2:0]                       state_dbg
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int FC_W  = (BLING_PERIOD > 1) ? $clog2(BLING_PERIOD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLING_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    SWAP  = 3'd4
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [NUM_LAYERS-1:0]   en_q;
  logic [TMR_W-1:0]        timer;
  logic [FC_W-1:0]         frame_cnt;

  logic                    sel_valid;
  logic                    sel_done;
  logic [COOR_WIDTH-1:0]   sel_x;
  logic [COOR_WIDTH-1:0]   sel_y;
  logic [PIX_WIDTH-1:0]    sel_pixel;

  assign state_dbg = state;

  // Only the painter at idx owns the write port; every other layer's strobes are ignored.
  always_comb begin
    sel_valid = 1'b0;
    sel_done  = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_pixel = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_valid = layer_valid[i];
        sel_done  = layer_done[i];
        sel_x     = layer_x[i*COOR_WIDTH +: COOR_WIDTH];
        sel_y     = layer_y[i*COOR_WIDTH +: COOR_WIDTH];
        sel_pixel = layer_pixel[i*PIX_WIDTH +: PIX_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      en_q         <= '0;
      timer        <= '0;
      frame_cnt    <= '0;
      layer_start  <= '0;
      fb_we        <= 1'b0;
      fb_x         <= '0;
      fb_y         <= '0;
      fb_pixel     <= '0;
      fb_swap      <= 1'b0;
      busy         <= 1'b0;
      show_bling   <= 1'b0;
      overrun_cnt  <= '0;
      timeout_flag <= 1'b0;
    end else begin
      layer_start <= '0;
      fb_we       <= 1'b0;
      fb_swap     <= 1'b0;

      // A tick that cannot start a frame is dropped and only counted.
      if (frame_tick && (state != IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (frame_tick) begin
            en_q  <= layer_en;
            idx   <= '0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          timer <= '0;
          if (en_q[idx]) begin
            layer_start <= NUM_LAYERS'(1) << idx;
            state       <= WAIT;
          end else begin
            state <= NEXT;
          end
        end
        WAIT: begin
          if (sel_valid) begin
            fb_we    <= 1'b1;
            fb_x     <= sel_x;
            fb_y     <= sel_y;
            fb_pixel <= sel_pixel;
          end
          if (sel_done) begin
            state <= NEXT;
          end else if (timer == TMR_LAST) begin
            timeout_flag <= 1'b1;
            state        <= NEXT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            fb_swap <= 1'b1;
            state   <= SWAP;
          end else begin
            idx   <= idx + 1'b1;
            state <= START;
          end
        end
        SWAP: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (frame_cnt == FC_LAST) begin
            frame_cnt  <= '0;
            show_bling <= bling_en ? ~show_bling : 1'b0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
